// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg
//   Shared definitions for the BCD seven-segment display driver:
//   - state_t : conversion FSM states
//   - SEG_*   : active-low gfedcba patterns for digits 0..9, blank and minus
//   - seg_polarity : maps an active-low pattern to the board polarity
//   - add3    : double-dabble nibble correction step
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Active-low patterns, bit order gfedcba (bit 6 = g, bit 0 = a).
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Patterns are kept active-low internally; invert only when the board
  // wants active-high segments.
  function automatic logic [6:0] seg_polarity(input logic [6:0] pat,
                                              input bit active_low);
    return active_low ? pat : ~pat;
  endfunction

  // Double-dabble correction: a nibble >= 5 would overflow past 9 after
  // the next shift, so pre-add 3 to carry into the next decade.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode
//   Combinational nibble to seven-segment decoder (active-low, gfedcba).
//   Ports:
//     digit : BCD nibble 0..9 (values 10..15 decode to blank)
//     blank : force the blank pattern regardless of digit
//     seg   : active-low segment pattern
module seg7_encode
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver
//   Captures a byte from the system data bus, converts it to three BCD
//   digits with a sequential shift-add-3 engine and drives registered
//   seven-segment outputs (units, tens, hundreds, sign).
//   Ports:
//     clk       : system clock
//     rst       : asynchronous active-low reset
//     bus       : 8-bit system data bus
//     OI        : output-in strobe; bus sampled on rising clk while OI=1
//     HEX0..2   : units / tens / hundreds segments
//     HEX3      : sign segments (minus or blank)
//     busy      : conversion in progress
//     done      : one-cycle pulse after new segment values are loaded
//     value_out : last byte that started a conversion
//
//   Handshake: OI is a valid-only strobe with no back-pressure. Every OI
//   cycle is accepted: it starts a conversion when idle with nothing
//   queued, otherwise it overwrites a one-entry pending slot (last writer
//   wins) that is drained automatically when the current conversion loads.
//   Capture -> display latency is a fixed 9 cycles.
module bcd_display_driver
  import bcd_display_pkg::*;
#(
  parameter bit SIGNED_MODE    = 1'b0,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus,
  input  logic       OI,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       busy,
  output logic       done,
  output logic [7:0] value_out
);

  localparam logic [6:0] RST_UNITS = seg_polarity(SEG_0, SEG_ACTIVE_LOW);
  localparam logic [6:0] RST_LEAD  =
    seg_polarity(BLANK_LEADING ? SEG_BLANK : SEG_0, SEG_ACTIVE_LOW);
  localparam logic [6:0] RST_SIGN  = seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  // An 8-bit magnitude suffices: the largest value (-128 or 255) fits.
  logic [7:0]  mag;
  logic        neg;
  logic [7:0]  pend_val;
  logic        pend_flag;

  logic        capture;
  logic        take_pend;
  logic        pend_set;
  logic [7:0]  cap_val;
  logic [7:0]  cap_mag;
  logic        cap_neg;

  logic [6:0]  seg_u;
  logic [6:0]  seg_t;
  logic [6:0]  seg_h;
  logic        blank_h;
  logic        blank_t;
  // The hundreds digit of an 8-bit value never exceeds 2, so the top bit
  // of the corrected accumulator is always shifted out as zero.
  logic        unused_bcd_msb;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    take_pend  = 1'b0;
    cap_val    = bus;
    case (state)
      IDLE: begin
        // A queued byte takes priority over a new strobe; the strobe then
        // lands in the pending slot instead of being lost.
        if (pend_flag) begin
          capture    = 1'b1;
          take_pend  = 1'b1;
          cap_val    = pend_val;
          state_next = SHIFT;
        end else if (OI) begin
          capture    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 4'd7) state_next = LOAD;
      end
      LOAD: begin
        // Chain straight into the queued conversion without an idle cycle.
        if (pend_flag) begin
          capture    = 1'b1;
          take_pend  = 1'b1;
          cap_val    = pend_val;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every OI not consumed directly by an idle capture goes to pending.
  assign pend_set = OI && !((state == IDLE) && !pend_flag);

  assign cap_neg = SIGNED_MODE && cap_val[7];
  assign cap_mag = cap_neg ? (~cap_val + 8'd1) : cap_val;

  assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign unused_bcd_msb = bcd_adj[11];

  assign busy = (state != IDLE);

  // ---------------- Segment encoders ----------------
  assign blank_h = BLANK_LEADING && (bcd[11:8] == 4'd0);
  assign blank_t = blank_h && (bcd[7:4] == 4'd0);

  seg7_encode u_enc_units (.digit(bcd[3:0]),  .blank(1'b0),    .seg(seg_u));
  seg7_encode u_enc_tens  (.digit(bcd[7:4]),  .blank(blank_t), .seg(seg_t));
  seg7_encode u_enc_hund  (.digit(bcd[11:8]), .blank(blank_h), .seg(seg_h));

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      bcd       <= '0;
      mag       <= '0;
      neg       <= 1'b0;
      pend_val  <= '0;
      pend_flag <= 1'b0;
      value_out <= '0;
      done      <= 1'b0;
      HEX0      <= RST_UNITS;
      HEX1      <= RST_LEAD;
      HEX2      <= RST_LEAD;
      HEX3      <= RST_SIGN;
    end else begin
      done <= 1'b0;

      if (capture) begin
        value_out <= cap_val;
        mag       <= cap_mag;
        neg       <= cap_neg;
        bcd       <= '0;
        cnt       <= '0;
      end else if (state == SHIFT) begin
        {bcd, mag} <= {bcd_adj[10:0], mag, 1'b0};
        cnt        <= cnt + 4'd1;
      end

      // Segment registers see the finished accumulator of the conversion
      // that just completed, even if a queued capture clears it this edge.
      if (state == LOAD) begin
        HEX0 <= seg_polarity(seg_u, SEG_ACTIVE_LOW);
        HEX1 <= seg_polarity(seg_t, SEG_ACTIVE_LOW);
        HEX2 <= seg_polarity(seg_h, SEG_ACTIVE_LOW);
        HEX3 <= seg_polarity(neg ? SEG_MINUS : SEG_BLANK, SEG_ACTIVE_LOW);
        done <= 1'b1;
      end

      if (pend_set) begin
        pend_val  <= bus;
        pend_flag <= 1'b1;
      end else if (take_pend) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bcd_display_driver.md
Name: bcd_display_driver

Overview:
- Downstream consumer of the 8-bit data bus: captures the bus value when OI is asserted.
- Converts the captured value to three BCD digits using a sequential shift-add-3 (double-dabble) engine.
- Drives four registered seven-segment outputs: units, tens, hundreds and sign.
- Sits between the bus/out_mux and the board HEX displays; replaces direct combinational decode of the output register.

Parameters:
- SIGNED_MODE, 0, 1 = interpret the captured byte as two's complement and show a minus sign on HEX3; 0 = unsigned 0..255.
- BLANK_LEADING, 1, 1 = blank leading-zero hundreds/tens digits; the units digit is always shown.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low in gfedcba order, as on the board; 0 = outputs inverted to active-high.

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  asynchronous, active-low reset; the integrator ties it directly to KEY[0]
- bus  in  8  system data bus
- OI  in  1  output-in control signal; the bus is sampled on a rising clk edge while OI=1
- HEX0  out  7  units digit segments
- HEX1  out  7  tens digit segments
- HEX2  out  7  hundreds digit segments
- HEX3  out  7  sign segments
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when new segment values are loaded
- value_out  out  8  last accepted raw byte

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, busy=0, done=0, value_out=0, pending flag=0.
  - HEX0 = '0' (1000000).
  - HEX1, HEX2 = blank (1111111) if BLANK_LEADING, else '0'.
  - HEX3 = blank.
- Active-low encodings (gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, minus=0111111
- Capture:
  - At edge N, with OI=1 and state=IDLE: latch bus into value_out.
  - Form the magnitude: if SIGNED_MODE and bus[7]=1, magnitude = (~bus+1) as a 9-bit value (so -128 gives 128) and neg=1; otherwise magnitude = bus and neg=0.
  - Clear the 12-bit BCD accumulator, set cnt=0, move to SHIFT.
- SHIFT (edges N+1..N+8):
  - Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd, mag} left by 1 and increment cnt.
  - After the 8th shift (cnt=7 to 8), move to LOAD.
- LOAD (edge N+9):
  - Register the segment encodings of the three nibbles into HEX0..HEX2.
  - HEX3 = minus if neg, else blank.
  - done=1 for exactly the cycle after edge N+9. Return to IDLE.
- busy=1 from after edge N through the cycle ending at edge N+9. Fixed latency: 9 cycles from capture to display update.
- OI while busy:
  - Store bus in a one-entry pending register and set the pending flag.
  - Later OI pulses overwrite the pending value (last writer wins).
  - On LOAD, if pending=1: capture the pending value (without needing OI) at the LOAD-to-IDLE edge, clear pending, and start SHIFT at the next edge. done still pulses for the completed conversion.
  - value_out updates only when a conversion starts.
- OI on the same edge as LOAD completes with pending=0: treated as an IDLE capture on the next edge. The bus value is held in pending, not lost.
- Leading blanking: if the hundreds nibble is 0, HEX2 is blank. If both hundreds and tens are 0, HEX1 is also blank.
- Reset mid-conversion: abort immediately, return to the reset display, drop pending.
- HEX outputs change only at LOAD or reset. They never show intermediate values.

Decomposition:
- Shared package bcd_display_pkg:
  - state enum {IDLE, SHIFT, LOAD}
  - ten digit segment constants plus SEG_BLANK and SEG_MINUS
  - function that applies SEG_ACTIVE_LOW inversion
- One sub-module, seg7_encode: combinational 4-bit nibble plus blank flag to 7-bit pattern, instantiated three times.
- The FSM and double-dabble datapath stay in bcd_display_driver.

Test Plan:
- Reset, then release: HEX0=1000000, HEX1=HEX2=HEX3=1111111, busy=0, done=0.
- OI with bus=8'd173: done pulses 9 cycles later. HEX2=1111001 ('1'), HEX1=1111000 ('7'), HEX0=0110000 ('3').
- OI with bus=8'd5, BLANK_LEADING=1: HEX2=HEX1=1111111, HEX0=0010010. With BLANK_LEADING=0, HEX1 and HEX2 both show 1000000.
- SIGNED_MODE=1 with bus=8'h80: display shows 128 and HEX3=0111111. With bus=8'hFF: shows 1 and HEX3=0111111.
- Back-to-back: OI bus=255, then OI bus=10 and OI bus=42 while busy. First done shows 255; the second conversion starts without OI and its done shows 42. value_out ends at 42; 10 is never displayed.
- Assert rst at SHIFT cycle 4 of a conversion of 99: outputs return to reset values immediately, no done pulse, and the pending value is discarded.
